// File: rtl/sddr_dram_responder.sv
// sddr_dram_responder: DDR3 device-side responder with per-bank row tracking, a burst store and sticky error flags; define SDDR_RESP_TIMING_CHECK_EN to build the tRCD/tRP/tRFC checks
module sddr_dram_responder #(
    parameter int BANK_BITS     = 3,
    parameter int ROW_BITS      = 13,
    parameter int COL_BITS      = 10,
    parameter int DATA_BITS     = 16,
    parameter int BURST_LENGTH  = 8,
    parameter int MEM_ADDR_BITS = 8,
    parameter int CL            = 6,
    parameter int CWL           = 5,
    parameter int T_RCD         = 6,
    parameter int T_RP          = 6,
    parameter int T_RFC         = 64
) (
    input  logic                         ddr_clock_i,
    input  logic                         ddr_reset_i,
    input  logic                         ddr3_cke_i,
    input  logic                         ddr3_cs_n_i,
    input  logic                         ddr3_ras_n_i,
    input  logic                         ddr3_cas_n_i,
    input  logic                         ddr3_we_n_i,
    input  logic [BANK_BITS-1:0]         ddr3_ba_i,
    input  logic [ROW_BITS:0]            ddr3_addr_i,
    input  logic [1:0][DATA_BITS-1:0]    ddr3_dq_i,
    output logic [1:0][DATA_BITS-1:0]    ddr3_dq_o,
    output logic                         ddr3_dq_valid_o,
    output logic [3:0]                   error_o,
    output logic [15:0]                  refresh_count_o
);
    localparam int BANKS     = 1 << BANK_BITS;
    localparam int PAIRS     = BURST_LENGTH / 2;
    localparam int PAIR_BITS = $clog2(PAIRS);
    localparam int BL_BITS   = $clog2(BURST_LENGTH);
    localparam int CNT_BITS  = $clog2(CL + CWL + PAIRS + 1);
    localparam logic [CNT_BITS-1:0] RD_FIRST = CNT_BITS'(CL);
    localparam logic [CNT_BITS-1:0] RD_LAST  = CNT_BITS'(CL + PAIRS - 1);
    localparam logic [CNT_BITS-1:0] WR_FIRST = CNT_BITS'(CWL);
    localparam logic [CNT_BITS-1:0] WR_LAST  = CNT_BITS'(CWL + PAIRS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} burst_t;

    burst_t                                state, state_next;
    logic [CNT_BITS-1:0]                   cnt;
    logic [MEM_ADDR_BITS-1:0]              b_addr, rw_addr;
    logic [BANK_BITS-1:0]                  b_bank;
    logic                                  b_ap;
    logic [PAIRS-2:0][1:0][DATA_BITS-1:0]  wbuf;
    logic [PAIRS-1:0][1:0][DATA_BITS-1:0]  mem [1 << MEM_ADDR_BITS];
    logic [BANKS-1:0]                      bank_open, open_now, closing;
    logic [ROW_BITS-1:0]                   bank_row [BANKS];
    logic                                  cmd_en, is_act, is_rd, is_wr, is_pre, is_ref, a10;
    logic                                  last, rd_beat, wr_beat, act_ok, rw_ok, ref_ok, proto_err, err_proto;
    logic [2:0]                            err_timing;
    logic                                  unused_addr;

    assign unused_addr = ddr3_addr_i[ROW_BITS];

    // Command decode, legality against the post-completion bank state, and next burst state
    always_comb begin
        cmd_en     = ddr3_cke_i && !ddr3_cs_n_i;
        is_act     = cmd_en && {ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i} == 3'b011;
        is_rd      = cmd_en && {ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i} == 3'b101;
        is_wr      = cmd_en && {ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i} == 3'b100;
        is_pre     = cmd_en && {ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i} == 3'b010;
        is_ref     = cmd_en && {ddr3_ras_n_i, ddr3_cas_n_i, ddr3_we_n_i} == 3'b001;
        a10        = ddr3_addr_i[10];
        last       = (state == READ && cnt == RD_LAST) || (state == WRITE && cnt == WR_LAST);
        rd_beat    = state == READ && cnt >= RD_FIRST;
        wr_beat    = state == WRITE && cnt >= WR_FIRST;
        closing    = '0;
        closing[b_bank] = last && b_ap;
        open_now   = bank_open & ~closing;
        act_ok     = is_act && !open_now[ddr3_ba_i];
        rw_ok      = (is_rd || is_wr) && open_now[ddr3_ba_i] && state == IDLE;
        ref_ok     = is_ref && open_now == '0;
        proto_err  = (is_act && !act_ok) || ((is_rd || is_wr) && !rw_ok) || (is_ref && !ref_ok) ||
                     (is_pre && state != IDLE && !last && b_ap && (a10 || ddr3_ba_i == b_bank));
        state_next = rw_ok ? (is_rd ? READ : WRITE) : last ? IDLE : state;
        rw_addr    = MEM_ADDR_BITS'({ddr3_ba_i, bank_row[ddr3_ba_i], ddr3_addr_i[COL_BITS-1:BL_BITS]});
        error_o    = {err_timing, err_proto};
    end

    // Burst engine state register
    always_ff @(posedge ddr_clock_i) begin
        if (ddr_reset_i) state <= IDLE;
        else state <= state_next;
    end

    // Burst datapath: beat counter, captured write beats and registered read beats
    always_ff @(posedge ddr_clock_i) begin
        if (ddr_reset_i) begin
            cnt             <= '0;
            ddr3_dq_o       <= '0;
            ddr3_dq_valid_o <= 1'b0;
        end else begin
            cnt             <= rw_ok ? CNT_BITS'(1) : cnt + CNT_BITS'(1);
            ddr3_dq_valid_o <= rd_beat;
            ddr3_dq_o       <= rd_beat ? mem[b_addr][PAIR_BITS'(cnt - RD_FIRST)] : '0;
            if (wr_beat && !last) wbuf[PAIR_BITS'(cnt - WR_FIRST)] <= ddr3_dq_i;
            if (rw_ok) begin
                b_addr <= rw_addr;
                b_bank <= ddr3_ba_i;
                b_ap   <= a10;
            end
        end
    end

    // Whole-burst commit on the last write beat; contents survive reset
    always_ff @(posedge ddr_clock_i) begin
        if (!ddr_reset_i && state == WRITE && last) mem[b_addr] <= {ddr3_dq_i, wbuf};
    end

    // Row latch on accepted ACT
    always_ff @(posedge ddr_clock_i) begin
        if (!ddr_reset_i && act_ok) bank_row[ddr3_ba_i] <= ddr3_addr_i[ROW_BITS-1:0];
    end

    // Bank open/close tracking, refresh counter and sticky protocol flag
    always_ff @(posedge ddr_clock_i) begin
        if (ddr_reset_i) begin
            bank_open       <= '0;
            refresh_count_o <= '0;
            err_proto       <= 1'b0;
        end else begin
            bank_open <= open_now;
            if (act_ok) bank_open[ddr3_ba_i] <= 1'b1;
            if (is_pre) bank_open <= a10 ? '0 : open_now & ~(BANKS'(1) << ddr3_ba_i);
            if (ref_ok) refresh_count_o <= refresh_count_o + 16'd1;
            err_proto <= err_proto | proto_err;
        end
    end

`ifdef SDDR_RESP_TIMING_CHECK_EN
    localparam int TW = $clog2(T_RFC + T_RCD + T_RP);
    localparam logic [TW-1:0] TRCD_L = TW'(T_RCD - 1);
    localparam logic [TW-1:0] TRP_L  = TW'(T_RP - 1);
    localparam logic [TW-1:0] TRFC_L = TW'(T_RFC - 1);

    logic [TW-1:0] trcd [BANKS];
    logic [TW-1:0] trp  [BANKS];
    logic [TW-1:0] trfc;

    // Saturating down-counters loaded with T-1 so a command exactly T cycles later sees zero
    always_ff @(posedge ddr_clock_i) begin
        if (ddr_reset_i) begin
            for (int b = 0; b < BANKS; b++) begin
                trcd[b] <= '0;
                trp[b]  <= '0;
            end
            trfc       <= '0;
            err_timing <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                trcd[b] <= act_ok && ddr3_ba_i == BANK_BITS'(b) ? TRCD_L : trcd[b] - TW'(trcd[b] != '0);
                trp[b]  <= (is_pre && (a10 || ddr3_ba_i == BANK_BITS'(b))) || closing[b] ? TRP_L
                                                                                        : trp[b] - TW'(trp[b] != '0);
            end
            trfc       <= ref_ok ? TRFC_L : trfc - TW'(trfc != '0);
            err_timing <= err_timing | {(act_ok || ref_ok) && trfc != '0,
                                        act_ok && trp[ddr3_ba_i] != '0,
                                        rw_ok && trcd[ddr3_ba_i] != '0};
        end
    end
`else
    localparam int unused_timing = T_RCD + T_RP + T_RFC;

    // Timing checks not built
    always_comb err_timing = '0;
`endif
endmodule

// File: tb/tb_sddr_dram_responder.sv
// tb_sddr_dram_responder: scoreboard bench for sddr_dram_responder; honours SDDR_RESP_TIMING_CHECK_EN for expected timing flags
module tb_sddr_dram_responder;
    localparam int CL = 6, CWL = 5, T_RP = 6, T_RFC = 64;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001;
`ifdef SDDR_RESP_TIMING_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic             clk, rst, cke, cs_n, ras_n, cas_n, we_n, dq_valid;
    logic [2:0]       ba;
    logic [13:0]      addr;
    logic [1:0][15:0] dq_i, dq_o;
    logic [3:0]       err;
    logic [15:0]      ref_cnt;

    exp_t        sb[$];
    logic [31:0] mm [256][4];
    logic [12:0] mrow [8];
    int          cyc = 0, errors = 0, checks = 0, vcount = 0, v0 = 0;

    sddr_dram_responder dut (
        .ddr_clock_i(clk), .ddr_reset_i(rst), .ddr3_cke_i(cke),
        .ddr3_cs_n_i(cs_n), .ddr3_ras_n_i(ras_n), .ddr3_cas_n_i(cas_n), .ddr3_we_n_i(we_n),
        .ddr3_ba_i(ba), .ddr3_addr_i(addr), .ddr3_dq_i(dq_i), .ddr3_dq_o(dq_o),
        .ddr3_dq_valid_o(dq_valid), .error_o(err), .refresh_count_o(ref_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] maddr(input logic [2:0] b, input logic [13:0] a);
        logic [22:0] f;
        f = {b, mrow[b], a[9:3]};
        return f[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] c, input logic [2:0] b, input logic [13:0] a);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        tick();
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic act(input logic [2:0] b, input logic [13:0] row);
        mrow[b] = row[12:0];
        drive(C_ACT, b, row);
    endtask

    task automatic wr(input logic [2:0] b, input logic [13:0] a, input logic [15:0] base);
        logic [7:0] m;
        m = maddr(b, a);
        drive(C_WR, b, a);
        repeat (CWL - 1) tick();
        for (int p = 0; p < 4; p++) begin
            dq_i[0] = base + 16'(2 * p);
            dq_i[1] = base + 16'(2 * p + 1);
            mm[m][p] = {dq_i[1], dq_i[0]};
            tick();
        end
        dq_i = '0;
    endtask

    task automatic rd(input logic [2:0] b, input logic [13:0] a);
        logic [7:0] m;
        m = maddr(b, a);
        drive(C_RD, b, a);
        for (int p = 0; p < 4; p++) sb.push_back('{cyc: cyc + CL + p, data: mm[m][p]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Read-side scoreboard: each expected beat must appear on exactly its edge
    always @(negedge clk) begin
        if (dq_valid) vcount++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check("rd_valid", 64'(dq_valid), 64'(1));
            check("rd_data", 64'(dq_o), 64'(sb[0].data));
            void'(sb.pop_front());
        end else if (dq_valid || dq_o != '0) begin
            check("idle_dq", {31'd0, dq_valid, dq_o}, 64'(0));
        end
    end

    initial begin
        rst = 1'b1;
        cke = 1'b1;
        {cs_n, ras_n, cas_n, we_n} = C_NOP;
        ba = '0;
        addr = '0;
        dq_i = '0;
        for (int i = 0; i < 256; i++) for (int p = 0; p < 4; p++) mm[i][p] = '0;
        for (int i = 0; i < 8; i++) mrow[i] = '0;
        repeat (3) tick();
        check("rst_valid", 64'(dq_valid), 64'(0));
        check("rst_dq", 64'(dq_o), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_refcnt", 64'(ref_cnt), 64'(0));
        rst = 1'b0;

        act(2, 14'h155);
        repeat (5) tick();
        wr(2, 14'h040, 16'h1000);
        repeat (5) tick();
        v0 = vcount;
        rd(2, 14'h040);
        repeat (CL + 5) tick();
        check("basic_vcount", 64'(vcount - v0), 64'(4));
        check("basic_err", 64'(err), 64'(0));

        v0 = vcount;
        rd(2, 14'h040);
        tick();
        drive(C_RD, 2, 14'h040);
        repeat (CL + 5) tick();
        check("b2b_vcount", 64'(vcount - v0), 64'(4));
        check("b2b_err", 64'(err), 64'(1));
        do_reset();
        check("err_cleared", 64'(err), 64'(0));

        drive(C_RD, 2, 14'h040);
        check("rd_idle_err", 64'(err), 64'(1));
        repeat (CL + 5) tick();
        do_reset();

        act(1, 14'h002);
        drive(C_ACT, 1, 14'h003);
        check("act_open_err", 64'(err), 64'(1));
        repeat (4) tick();
        wr(1, 14'h000, 16'h2000);
        drive(C_REF, 0, 14'h000);
        check("ref_open_err", 64'(err), 64'(1));
        check("ref_open_cnt", 64'(ref_cnt), 64'(0));
        drive(C_PRE, 1, 14'h000);
        repeat (T_RP - 1) tick();
        act(1, 14'h000);
        repeat (5) tick();
        rd(1, 14'h000);
        repeat (CL + 5) tick();
        check("alias_err", 64'(err), 64'(1));
        do_reset();

        act(3, 14'h010);
        repeat (5) tick();
        wr(3, 14'h408, 16'h3000);
        repeat (T_RP - 2) tick();
        act(3, 14'h010);
        check("ap_early_err", 64'(err), TCHK ? 64'(4'b0100) : 64'(0));
        repeat (5) tick();
        rd(3, 14'h008);
        repeat (CL + 5) tick();
        do_reset();

        act(3, 14'h010);
        repeat (5) tick();
        wr(3, 14'h408, 16'h3100);
        repeat (T_RP - 1) tick();
        act(3, 14'h010);
        check("ap_ok_err", 64'(err), 64'(0));
        do_reset();

        act(0, 14'h000);
        repeat (5) tick();
        drive(C_WR, 0, 14'h010);
        repeat (CWL - 1) tick();
        dq_i = {16'h4001, 16'h4000};
        tick();
        dq_i = {16'h4003, 16'h4002};
        rst = 1'b1;
        tick();
        check("wrabort_valid", 64'(dq_valid), 64'(0));
        check("wrabort_dq", 64'(dq_o), 64'(0));
        check("wrabort_err", 64'(err), 64'(0));
        check("wrabort_refcnt", 64'(ref_cnt), 64'(0));
        tick();
        rst = 1'b0;
        dq_i = '0;
        act(0, 14'h000);
        repeat (5) tick();
        rd(0, 14'h010);
        repeat (CL + 5) tick();
        check("wrabort_rd_err", 64'(err), 64'(0));

        act(2, 14'h155);
        repeat (5) tick();
        drive(C_REF, 0, 14'h000);
        check("ref_busy_err", 64'(err), 64'(1));
        rd(2, 14'h040);
        repeat (CL) tick();
        @(negedge clk);
        #1;
        sb.delete();
        rst = 1'b1;
        tick();
        check("rdabort_valid", 64'(dq_valid), 64'(0));
        check("rdabort_dq", 64'(dq_o), 64'(0));
        check("rdabort_err", 64'(err), 64'(0));
        rst = 1'b0;
        repeat (2) tick();

        drive(C_REF, 0, 14'h000);
        repeat (T_RFC - 1) tick();
        drive(C_REF, 0, 14'h000);
        repeat (T_RFC - 1) tick();
        drive(C_REF, 0, 14'h000);
        check("ref3_cnt", 64'(ref_cnt), 64'(3));
        check("ref3_err", 64'(err), 64'(0));
        repeat (T_RFC - 2) tick();
        drive(C_REF, 0, 14'h000);
        check("ref_early_cnt", 64'(ref_cnt), 64'(4));
        check("ref_early_err", 64'(err), TCHK ? 64'(4'b1000) : 64'(0));
        cke = 1'b0;
        drive(C_REF, 0, 14'h000);
        cke = 1'b1;
        check("cke_low_cnt", 64'(ref_cnt), 64'(4));

        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
